// File: rtl/ofm_drain_unit.sv
// OFM drain: snapshot column accumulators, clamp, and stream
// them into OFM SRAM in filter-major order across a layer.
module ofm_drain_unit #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int ACC_W         = 32,
  parameter int DATA_W        = 16,
  parameter int NO_FILTER     = 20,
  parameter int OFM_PIXELS    = 4,
  parameter int ADDR_W        = 16,
  parameter int RELU          = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           drain_start,
  input  logic [SYSTOLIC_SIZE*ACC_W-1:0] acc_in,
  output logic                           mem_wr_valid,
  input  logic                           mem_wr_ready,
  output logic [ADDR_W-1:0]              mem_wr_addr,
  output logic [DATA_W-1:0]              mem_wr_data,
  output logic                           busy,
  output logic                           layer_done,
  output logic                           overrun,
  input  logic                           clr_overrun
);

  localparam int NO_GROUP =
    (NO_FILTER + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int CW =
    SYSTOLIC_SIZE > 1 ? $clog2(SYSTOLIC_SIZE) : 1;
  localparam int GW = NO_GROUP > 1 ? $clog2(NO_GROUP) : 1;
  localparam int PW = OFM_PIXELS > 1 ? $clog2(OFM_PIXELS) : 1;

  localparam logic [PW-1:0] PIX_LAST = PW'(OFM_PIXELS - 1);
  localparam logic [GW-1:0] GRP_LAST = GW'(NO_GROUP - 1);

  localparam logic signed [ACC_W-1:0] MAXV =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    FINISH
  } state_e;

  state_e                   state_q, state_d;
  logic [CW-1:0]            col_q, col_d;
  logic [PW-1:0]            pixel_q, pixel_d;
  logic [GW-1:0]            group_q, group_d;
  logic                     done_q, done_d;
  logic                     ovr_q, ovr_d;
  logic                     cap;
  logic [CW-1:0]            last_col;
  logic signed [ACC_W-1:0]  shadow_q [SYSTOLIC_SIZE];
  logic signed [ACC_W-1:0]  sel;
  logic [DATA_W-1:0]        clamped;

  // Highest written column for the current filter group
  always_comb begin
    int rem;
    rem = NO_FILTER - int'(group_q) * SYSTOLIC_SIZE;
    if (rem > SYSTOLIC_SIZE) rem = SYSTOLIC_SIZE;
    last_col = CW'(rem - 1);
  end

  // Next-state and position counters
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    pixel_d = pixel_q;
    group_d = group_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (drain_start) begin
          cap     = 1'b1;
          col_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_wr_ready) begin
          if (col_q == last_col) state_d = FINISH;
          else col_d = col_q + 1'b1;
        end
      end
      FINISH: begin
        state_d = IDLE;
        if (pixel_q == PIX_LAST) begin
          pixel_d = '0;
          if (group_q == GRP_LAST) begin
            group_d = '0;
            done_d  = 1'b1;
          end else begin
            group_d = group_q + 1'b1;
          end
        end else begin
          pixel_d = pixel_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky overrun; a new overrun beats a same-cycle clear
  always_comb begin
    ovr_d = ovr_q;
    if (drain_start && state_q != IDLE) ovr_d = 1'b1;
    else if (clr_overrun) ovr_d = 1'b0;
  end

  // Control state and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      pixel_q <= '0;
      group_q <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      pixel_q <= pixel_d;
      group_q <= group_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  // Shadow copy frees the PE accumulators for the next tile
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++)
        shadow_q[c] <= '0;
    end else if (cap) begin
      for (int c = 0; c < SYSTOLIC_SIZE; c++)
        shadow_q[c] <= acc_in[c*ACC_W +: ACC_W];
    end
  end

  // ReLU and saturation of the selected column
  always_comb begin
    sel = shadow_q[col_q];
    if (RELU != 0 && sel < 0)
      clamped = '0;
    else if (sel > MAXV)
      clamped = MAXV[DATA_W-1:0];
    else if (sel < MINV)
      clamped = MINV[DATA_W-1:0];
    else
      clamped = sel[DATA_W-1:0];
  end

  // Write port; address/data read zero outside a drain
  always_comb begin
    mem_wr_valid = (state_q == DRAIN);
    mem_wr_addr  = '0;
    mem_wr_data  = '0;
    if (mem_wr_valid) begin
      mem_wr_addr = ADDR_W'((int'(group_q) * SYSTOLIC_SIZE
                    + int'(col_q)) * OFM_PIXELS + int'(pixel_q));
      mem_wr_data = clamped;
    end
  end

  assign busy       = (state_q != IDLE);
  assign layer_done = done_q;
  assign overrun    = ovr_q;

endmodule

// File: doc/ofm_drain_unit.md
# ofm_drain_unit

Output write-back engine for the systolic array. On a drain request it snapshots the SYSTOLIC_SIZE column accumulators into a shadow register, freeing the PEs for the next tile. It then clamps each value (with optional ReLU) and writes one value per handshake beat into OFM SRAM at a computed filter-major address. It tracks pixel and filter-group position across a whole layer and pulses `layer_done` after the last group.

## Interface
- SYSTOLIC_SIZE, 16, number of PE columns (one filter per column)
- ACC_W, 32, signed accumulator width per column
- DATA_W, 16, signed OFM word width
- NO_FILTER, 20, total filters in layer
- OFM_PIXELS, 4, output pixels per filter (drains per filter group)
- ADDR_W, 16, OFM SRAM address width
- RELU, 1, 1 = clamp negatives to 0

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- drain_start  in  1  single-cycle request; accumulators valid this cycle
- acc_in  in  SYSTOLIC_SIZE*ACC_W  column accumulators, column c at bits [c*ACC_W +: ACC_W]
- mem_wr_valid  out  1  write beat valid
- mem_wr_ready  in  1  SRAM accepts beat
- mem_wr_addr  out  ADDR_W  write address
- mem_wr_data  out  DATA_W  write data
- busy  out  1  drain in progress
- layer_done  out  1  one-cycle pulse after final beat of layer
- overrun  out  1  sticky: drain_start received while busy
- clr_overrun  in  1  clears overrun

## Operation
- NO_GROUP = ceil(NO_FILTER/SYSTOLIC_SIZE). Counters: pixel (0..OFM_PIXELS-1), group (0..NO_GROUP-1), col (0..SYSTOLIC_SIZE-1).
- last_col = min(SYSTOLIC_SIZE, NO_FILTER - group*SYSTOLIC_SIZE) - 1. Columns above last_col are never written.
- States:
  - IDLE: drain_start → capture acc_in into shadow, col=0 → DRAIN.
  - DRAIN: beat accepted (valid&ready) with col==last_col → FINISH; else col+1.
  - FINISH (1 cycle): pixel+1; on wrap to 0, group+1; on group wrap to 0 assert layer_done. → IDLE.
- Address = ((group*SYSTOLIC_SIZE + col)*OFM_PIXELS + pixel) mod 2^ADDR_W.
- Data: shadow[col] is signed.
  - RELU=1 and value<0 → 0.
  - Otherwise clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1], keeping the low DATA_W bits when in range.
- drain_start in DRAIN or FINISH:
  - request is dropped and overrun is set;
  - shadow and counters are unaffected.
- clr_overrun clears overrun. If clr_overrun and a new overrun occur in the same cycle, set wins.
- Reset mid-layer: all counters, shadow and state return to zero/IDLE. A partially written drain is abandoned.

## Timing
- Reset values: mem_wr_valid=0, mem_wr_addr=0, mem_wr_data=0, busy=0, layer_done=0, overrun=0.
- drain_start sampled at edge T → busy=1 and mem_wr_valid=1 from T+1, with col 0 address/data registered.
- Valid/ready:
  - While valid&!ready, addr/data are held stable and valid stays high.
  - Each accepted beat presents the next column on the following cycle, so with ready tied high there is one beat per cycle.
- Drain length with ready=1: (last_col+1) beats + 1 FINISH cycle. busy falls in the cycle after FINISH. The earliest accepted next drain_start is the cycle busy=0.
- layer_done is high during the cycle after FINISH, coincident with busy=0.
- acc_in is only sampled on the accepted drain_start edge.

## Test plan
- Full layer, defaults, ready=1:
  - 8 drains: 4 pixels × 2 groups.
  - 16+16+16+16+4+4+4+4 = 80 beats.
  - Group 1 addresses are 64..79 only.
  - Exactly one layer_done, after drain 8.
- Address check: group 0, pixel 2, col 5 → addr 22; group 1, pixel 3, col 3 → addr (19*4+3)=79.
- Clamping, RELU=1: acc values 70000, -5, 1234, -70000 → 32767, 0, 1234, 0. With RELU=0, -70000 → -32768 and -5 → -5.
- Backpressure: ready low for 3 cycles mid-drain at col 7 → addr/data for col 7 held unchanged, no beat lost or duplicated, total beats still 16.
- Overrun: drain_start at the 2nd cycle of DRAIN → overrun=1, the current drain completes with the original data, and the pixel counter advances once. clr_overrun → overrun=0.
- Reset mid-drain at col 9: outputs go to reset values immediately. The next drain writes pixel 0, group 0, starting at addr 0.
